alu_ctrl_ex_me: RTL and testbench
=================================

ALU_CTRL_EX_ME -- requirements
Module: alu_ctrl_ex_me

Interface
REQ-001 Parameter DW, default 32, datapath width; only 32 is supported.
REQ-002 Parameter LUI_SHAMT, default 16, constant used as ALU operand A for lui.
REQ-003 One clock and a synchronous, active-high reset, named clk and rst; clk is the sole clock and every register updates only on its rising edge.
REQ-004 Ports are as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- ctrl_alu  out  4  ALU opcode
- ctrl_regdst  out  1  1=rd, 0=rt
- ctrl_alusrca  out  2  0=rs, 1=LUI_SHAMT, 2=shamt
- ctrl_alusrcb  out  2  0=rt, 1=imm
- ctrl_mem2reg  out  1  load result
- ctrl_ext  out  1  1=sign-extend, 0=zero-extend
- ctrl_regwr  out  1  register write
- ctrl_memwr  out  1  memory write
- ctrl_branch  out  2  01=beq, 10=bne
- ctrl_jump  out  1  j
- ex_alu_op  in  4  ALU opcode
- ex_alusrca  in  2  operand A select
- ex_alusrcb  in  2  operand B select
- ex_regdst  in  1  destination select
- ex_rs_val  in  32  forwarded rs
- ex_rt_val  in  32  forwarded rt
- ex_imm  in  32  extended immediate
- ex_shamt  in  5  shift amount
- ex_rt  in  5  rt index
- ex_rd  in  5  rd index
- ex_mem2reg, ex_memwr, ex_regwr  in  1 each  control
- ex_alu_out  out  32  combinational ALU result
- ex_wr_idx  out  5  combinational destination index
- me_alu_out  out  32  registered
- me_wdata  out  32  registered ex_rt_val
- me_wr_idx  out  5  registered
- me_mem2reg, me_memwr, me_regwr  out  1 each  registered

Function
REQ-005 The decoder SHALL be purely combinational and SHALL drive all ctrl_* outputs to 0 for any undefined op/funct (NOP).
REQ-006 For op=0x00, the decoder SHALL set regdst=1 and regwr=1, and SHALL select by funct: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU, all with alusrca=0 and alusrcb=0; 0x00 SLL, 0x02 SRL, 0x03 SRA, all with alusrca=2.
REQ-007 I-type instructions SHALL use alusrcb=1, regdst=0 and regwr=1, decoded as: addi 0x08 and addiu 0x09 ADD with ext=1; slti 0x0A SLT with ext=1; sltiu 0x0B SLTU with ext=1; andi 0x0C AND with ext=0; ori 0x0D OR with ext=0; xori 0x0E XOR with ext=0; lui 0x0F SLL with alusrca=1 and ext=0.
REQ-008 lw 0x23 SHALL decode as ADD, ext=1, alusrcb=1, mem2reg=1, regwr=1.
REQ-009 sw 0x2B SHALL decode as ADD, ext=1, alusrcb=1, memwr=1, regwr=0.
REQ-010 beq 0x04 SHALL decode as branch=01 with ext=1; bne 0x05 as branch=10 with ext=1; j 0x02 as jump=1; none of the three SHALL write a register.
REQ-011 ALU opcode encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA; opcodes 11-15 SHALL produce 0.
REQ-012 Shifts SHALL compute B shifted by A[4:0]; add and sub SHALL wrap modulo 2^32 with no overflow trap; SLT and SLTU SHALL produce 1 or 0.
REQ-013 Operand A SHALL be selected by ex_alusrca as: 0 ex_rs_val, 1 LUI_SHAMT, 2 zero-extended ex_shamt, 3 zero.
REQ-014 Operand B SHALL be selected by ex_alusrcb as: 0 ex_rt_val, 1 ex_imm, 2 and 3 zero.
REQ-015 ex_wr_idx SHALL equal ex_regdst ? ex_rd : ex_rt.
REQ-016 Each rising clk edge SHALL latch ex_alu_out, ex_rt_val, ex_wr_idx, ex_mem2reg, ex_memwr and ex_regwr into the corresponding me_* outputs, giving 1-cycle latency with no stall input.

Reset
REQ-017 With rst=1 at a rising edge, all me_* outputs SHALL become 0; rst SHALL take precedence over flush and data.
REQ-018 Combinational outputs (ctrl_*, ex_alu_out, ex_wr_idx) SHALL NOT be affected by rst.

Configuration
REQ-019 When macro EXME_FLUSH_EN is defined, the module SHALL have an input port flush (1 bit) and, when flush=1 at an edge, SHALL clear me_mem2reg, me_memwr and me_regwr while still latching the data fields.
REQ-020 When EXME_FLUSH_EN is undefined, the flush port SHALL be absent and the register SHALL always load.

Structure
REQ-021 The ALU opcode constants, the alusrca/alusrcb encodings, and the op/funct constants SHALL reside in a shared package alu_ctrl_pkg.
REQ-022 The ALU SHALL be a sub-module named alu_core; the decoder and the EX/ME register SHALL be inline.

Verification
REQ-023 Decode check: op=0x0F -> ctrl_alu=8, alusrca=1, alusrcb=1, ext=0, regwr=1, regdst=0; then ex_imm=0x00001234 -> ex_alu_out=0x12340000.
REQ-024 Signed compare: SLT with A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-025 Arithmetic shift: SRA with ex_alusrca=2, ex_shamt=4, B=0x80000000 -> 0xF8000000; SUB 0 - 1 -> 0xFFFFFFFF.
REQ-026 Store path: sw decode fed into the EX inputs with rs=0x100, imm=8, rt_val=0xDEAD -> after one edge me_alu_out=0x108, me_wdata=0xDEAD, me_memwr=1, me_regwr=0.
REQ-027 Reset: all me_* outputs nonzero, rst=1 for one edge -> all me_* outputs 0; with op=0x3F -> all ctrl_* outputs 0.
REQ-028 Flush (with EXME_FLUSH_EN defined): flush=1 with ex_regwr=1 -> me_regwr=0 and me_alu_out still loaded.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU opcodes, operand-select encodings and MIPS op/funct constants
// Contents: alu_op_e (4-bit ALU opcode), srca_e / srcb_e (operand selects),
//           OP_* (instr[31:26]) and FN_* (instr[5:0]) constants, XLEN.
package alu_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCA_RS    = 2'd0,
    SRCA_LUI   = 2'd1,
    SRCA_SHAMT = 2'd2,
    SRCA_ZERO  = 2'd3
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RT   = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_ZERO = 2'd2
  } srcb_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/alu_ctrl_ex_me_if.sv
// rtl/alu_ctrl_ex_me_if.sv - decode / execute / EX-ME register signal bundle
// Modports: slave  - the alu_ctrl_ex_me block (decode in, ctrl out, EX in, ALU/ME out)
//           master - the surrounding pipeline (drives op/funct and EX inputs)
interface alu_ctrl_ex_me_if;
  import alu_ctrl_pkg::*;

  // decode
  logic [5:0]      op;
  logic [5:0]      funct;
  logic [3:0]      ctrl_alu;
  logic            ctrl_regdst;
  logic [1:0]      ctrl_alusrca;
  logic [1:0]      ctrl_alusrcb;
  logic            ctrl_mem2reg;
  logic            ctrl_ext;
  logic            ctrl_regwr;
  logic            ctrl_memwr;
  logic [1:0]      ctrl_branch;
  logic            ctrl_jump;
  // execute
  logic [3:0]      ex_alu_op;
  logic [1:0]      ex_alusrca;
  logic [1:0]      ex_alusrcb;
  logic            ex_regdst;
  logic [XLEN-1:0] ex_rs_val;
  logic [XLEN-1:0] ex_rt_val;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_shamt;
  logic [4:0]      ex_rt;
  logic [4:0]      ex_rd;
  logic            ex_mem2reg;
  logic            ex_memwr;
  logic            ex_regwr;
  logic [XLEN-1:0] ex_alu_out;
  logic [4:0]      ex_wr_idx;
  // memory stage
  logic [XLEN-1:0] me_alu_out;
  logic [XLEN-1:0] me_wdata;
  logic [4:0]      me_wr_idx;
  logic            me_mem2reg;
  logic            me_memwr;
  logic            me_regwr;

  modport slave (
    input  op, funct,
    output ctrl_alu, ctrl_regdst, ctrl_alusrca, ctrl_alusrcb, ctrl_mem2reg,
           ctrl_ext, ctrl_regwr, ctrl_memwr, ctrl_branch, ctrl_jump,
    input  ex_alu_op, ex_alusrca, ex_alusrcb, ex_regdst, ex_rs_val, ex_rt_val,
           ex_imm, ex_shamt, ex_rt, ex_rd, ex_mem2reg, ex_memwr, ex_regwr,
    output ex_alu_out, ex_wr_idx,
    output me_alu_out, me_wdata, me_wr_idx, me_mem2reg, me_memwr, me_regwr
  );

  modport master (
    output op, funct,
    input  ctrl_alu, ctrl_regdst, ctrl_alusrca, ctrl_alusrcb, ctrl_mem2reg,
           ctrl_ext, ctrl_regwr, ctrl_memwr, ctrl_branch, ctrl_jump,
    output ex_alu_op, ex_alusrca, ex_alusrcb, ex_regdst, ex_rs_val, ex_rt_val,
           ex_imm, ex_shamt, ex_rt, ex_rd, ex_mem2reg, ex_memwr, ex_regwr,
    input  ex_alu_out, ex_wr_idx,
    input  me_alu_out, me_wdata, me_wr_idx, me_mem2reg, me_memwr, me_regwr
  );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 32-bit integer ALU
// Ports: op (4-bit alu_op_e), a, b (operands), y (result). Shifts move b by a[4:0];
//        add/sub wrap; unused opcodes 11-15 yield 0.
module alu_core
  import alu_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  logic [4:0] sh;
  assign sh = a[4:0];

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(DW-1){1'b0}}, (a < b)};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = $unsigned($signed(b) >>> sh);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_ex_me.sv
// rtl/alu_ctrl_ex_me.sv - MIPS control decoder, EX-stage ALU with operand muxing, EX/ME register
// Ports: clk, rst (sync active-high, clears me_* only), bus (alu_ctrl_ex_me_if.slave),
//        flush (only when EXME_FLUSH_EN is defined: squashes me_* control bits, data still loads).
// Config macro: EXME_FLUSH_EN
module alu_ctrl_ex_me
  import alu_ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter int LUI_SHAMT = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef EXME_FLUSH_EN
  input  logic              flush,
`endif
  alu_ctrl_ex_me_if.slave   bus
);

  // ---------------- decoder ----------------
  always_comb begin
    bus.ctrl_alu     = ALU_ADD;
    bus.ctrl_regdst  = 1'b0;
    bus.ctrl_alusrca = SRCA_RS;
    bus.ctrl_alusrcb = SRCB_RT;
    bus.ctrl_mem2reg = 1'b0;
    bus.ctrl_ext     = 1'b0;
    bus.ctrl_regwr   = 1'b0;
    bus.ctrl_memwr   = 1'b0;
    bus.ctrl_branch  = 2'b00;
    bus.ctrl_jump    = 1'b0;

    case (bus.op)
      OP_RTYPE: begin
        // regdst/regwr only for recognised funct so unknown R-types stay a NOP
        bus.ctrl_regdst = 1'b1;
        bus.ctrl_regwr  = 1'b1;
        case (bus.funct)
          FN_ADD, FN_ADDU: bus.ctrl_alu = ALU_ADD;
          FN_SUB, FN_SUBU: bus.ctrl_alu = ALU_SUB;
          FN_AND:          bus.ctrl_alu = ALU_AND;
          FN_OR:           bus.ctrl_alu = ALU_OR;
          FN_XOR:          bus.ctrl_alu = ALU_XOR;
          FN_NOR:          bus.ctrl_alu = ALU_NOR;
          FN_SLT:          bus.ctrl_alu = ALU_SLT;
          FN_SLTU:         bus.ctrl_alu = ALU_SLTU;
          FN_SLL: begin
            bus.ctrl_alu     = ALU_SLL;
            bus.ctrl_alusrca = SRCA_SHAMT;
          end
          FN_SRL: begin
            bus.ctrl_alu     = ALU_SRL;
            bus.ctrl_alusrca = SRCA_SHAMT;
          end
          FN_SRA: begin
            bus.ctrl_alu     = ALU_SRA;
            bus.ctrl_alusrca = SRCA_SHAMT;
          end
          default: begin
            bus.ctrl_regdst = 1'b0;
            bus.ctrl_regwr  = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        bus.ctrl_alu     = ALU_ADD;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_ext     = 1'b1;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_SLTI: begin
        bus.ctrl_alu     = ALU_SLT;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_ext     = 1'b1;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_SLTIU: begin
        bus.ctrl_alu     = ALU_SLTU;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_ext     = 1'b1;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_ANDI: begin
        bus.ctrl_alu     = ALU_AND;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_ORI: begin
        bus.ctrl_alu     = ALU_OR;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_XORI: begin
        bus.ctrl_alu     = ALU_XOR;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_LUI: begin
        // lui = imm << LUI_SHAMT, reusing the SLL path with a constant A operand
        bus.ctrl_alu     = ALU_SLL;
        bus.ctrl_alusrca = SRCA_LUI;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_LW: begin
        bus.ctrl_alu     = ALU_ADD;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_ext     = 1'b1;
        bus.ctrl_mem2reg = 1'b1;
        bus.ctrl_regwr   = 1'b1;
      end
      OP_SW: begin
        bus.ctrl_alu     = ALU_ADD;
        bus.ctrl_alusrcb = SRCB_IMM;
        bus.ctrl_ext     = 1'b1;
        bus.ctrl_memwr   = 1'b1;
      end
      OP_BEQ: begin
        bus.ctrl_branch = 2'b01;
        bus.ctrl_ext    = 1'b1;
      end
      OP_BNE: begin
        bus.ctrl_branch = 2'b10;
        bus.ctrl_ext    = 1'b1;
      end
      OP_J: begin
        bus.ctrl_jump = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- execute ----------------
  localparam logic [DW-1:0] LUI_A = DW'(LUI_SHAMT);

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;

  always_comb begin
    alu_a = '0;
    case (bus.ex_alusrca)
      SRCA_RS:    alu_a = bus.ex_rs_val;
      SRCA_LUI:   alu_a = LUI_A;
      SRCA_SHAMT: alu_a = {{(DW-5){1'b0}}, bus.ex_shamt};
      default:    alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (bus.ex_alusrcb)
      SRCB_RT:  alu_b = bus.ex_rt_val;
      SRCB_IMM: alu_b = bus.ex_imm;
      default:  alu_b = '0;
    endcase
  end

  alu_core #(.DW(DW)) u_alu (
    .op (bus.ex_alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (bus.ex_alu_out)
  );

  assign bus.ex_wr_idx = bus.ex_regdst ? bus.ex_rd : bus.ex_rt;

  // ---------------- EX/ME register ----------------
  logic kill_ctrl;
`ifdef EXME_FLUSH_EN
  assign kill_ctrl = flush;
`else
  assign kill_ctrl = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.me_alu_out <= '0;
      bus.me_wdata   <= '0;
      bus.me_wr_idx  <= '0;
      bus.me_mem2reg <= 1'b0;
      bus.me_memwr   <= 1'b0;
      bus.me_regwr   <= 1'b0;
    end else begin
      bus.me_alu_out <= bus.ex_alu_out;
      bus.me_wdata   <= bus.ex_rt_val;
      bus.me_wr_idx  <= bus.ex_wr_idx;
      // a flushed slot keeps its data but can no longer write anything
      bus.me_mem2reg <= bus.ex_mem2reg & ~kill_ctrl;
      bus.me_memwr   <= bus.ex_memwr   & ~kill_ctrl;
      bus.me_regwr   <= bus.ex_regwr   & ~kill_ctrl;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_ex_me.sv
// tb/tb_alu_ctrl_ex_me.sv - directed table-driven bench for alu_ctrl_ex_me
module tb_alu_ctrl_ex_me;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef EXME_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_ctrl_ex_me_if bus ();

  alu_ctrl_ex_me #(.DW(32), .LUI_SHAMT(16)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef EXME_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // {alu, regdst, srca, srcb, mem2reg, ext, regwr, memwr, branch, jump}
  function automatic logic [15:0] ctrl_vec();
    return {bus.ctrl_alu, bus.ctrl_regdst, bus.ctrl_alusrca, bus.ctrl_alusrcb,
            bus.ctrl_mem2reg, bus.ctrl_ext, bus.ctrl_regwr, bus.ctrl_memwr,
            bus.ctrl_branch, bus.ctrl_jump};
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] exp;
  } dec_vec_t;

  typedef struct {
    string       name;
    logic [3:0]  alu;
    logic [1:0]  srca;
    logic [1:0]  srcb;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } alu_vec_t;

  function automatic logic [15:0] mk(input logic [3:0] alu, input logic rd, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic m2r, input logic ext,
                                     input logic rw, input logic mw, input logic [1:0] br,
                                     input logic j);
    return {alu, rd, sa, sb, m2r, ext, rw, mw, br, j};
  endfunction

  dec_vec_t dv[16];
  alu_vec_t av[13];

  task automatic clear_ex();
    bus.ex_alu_op  = 4'd0; bus.ex_alusrca = 2'd0; bus.ex_alusrcb = 2'd0;
    bus.ex_regdst  = 1'b0; bus.ex_rs_val  = '0;   bus.ex_rt_val  = '0;
    bus.ex_imm     = '0;   bus.ex_shamt   = '0;   bus.ex_rt      = '0;
    bus.ex_rd      = '0;   bus.ex_mem2reg = 1'b0; bus.ex_memwr   = 1'b0;
    bus.ex_regwr   = 1'b0;
  endtask

  initial begin
    //              name        op     funct   alu rd sa sb m2r ext rw mw br   j
    dv[0]  = '{"r_add",  6'h00, 6'h20, mk(4'd0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0)};
    dv[1]  = '{"r_subu", 6'h00, 6'h23, mk(4'd1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0)};
    dv[2]  = '{"r_slt",  6'h00, 6'h2A, mk(4'd6, 1, 0, 0, 0, 0, 1, 0, 2'b00, 0)};
    dv[3]  = '{"r_sra",  6'h00, 6'h03, mk(4'd10,1, 2, 0, 0, 0, 1, 0, 2'b00, 0)};
    dv[4]  = '{"r_sll",  6'h00, 6'h00, mk(4'd8, 1, 2, 0, 0, 0, 1, 0, 2'b00, 0)};
    dv[5]  = '{"r_undef",6'h00, 6'h01, mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)};
    dv[6]  = '{"addi",   6'h08, 6'h11, mk(4'd0, 0, 0, 1, 0, 1, 1, 0, 2'b00, 0)};
    dv[7]  = '{"andi",   6'h0C, 6'h00, mk(4'd2, 0, 0, 1, 0, 0, 1, 0, 2'b00, 0)};
    dv[8]  = '{"lui",    6'h0F, 6'h00, mk(4'd8, 0, 1, 1, 0, 0, 1, 0, 2'b00, 0)};
    dv[9]  = '{"sltiu",  6'h0B, 6'h00, mk(4'd7, 0, 0, 1, 0, 1, 1, 0, 2'b00, 0)};
    dv[10] = '{"lw",     6'h23, 6'h00, mk(4'd0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 0)};
    dv[11] = '{"sw",     6'h2B, 6'h00, mk(4'd0, 0, 0, 1, 0, 1, 0, 1, 2'b00, 0)};
    dv[12] = '{"beq",    6'h04, 6'h00, mk(4'd0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 0)};
    dv[13] = '{"bne",    6'h05, 6'h00, mk(4'd0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 0)};
    dv[14] = '{"j",      6'h02, 6'h00, mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1)};
    dv[15] = '{"undef3f",6'h3F, 6'h20, mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0)};

    //              name        alu    sa    sb    rs            rt            imm           sh    exp
    av[0]  = '{"lui_imm",  4'd8,  2'd1, 2'd1, 32'h0,        32'h0,        32'h00001234, 5'd0, 32'h12340000};
    av[1]  = '{"slt_neg",  4'd6,  2'd0, 2'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0, 32'h1};
    av[2]  = '{"sltu_neg", 4'd7,  2'd0, 2'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        5'd0, 32'h0};
    av[3]  = '{"sra",      4'd10, 2'd2, 2'd0, 32'h0,        32'h80000000, 32'h0,        5'd4, 32'hF8000000};
    av[4]  = '{"sub_wrap", 4'd1,  2'd0, 2'd0, 32'h0,        32'h1,        32'h0,        5'd0, 32'hFFFFFFFF};
    av[5]  = '{"add_wrap", 4'd0,  2'd0, 2'd0, 32'hFFFFFFFF, 32'h2,        32'h0,        5'd0, 32'h1};
    av[6]  = '{"nor",      4'd5,  2'd0, 2'd0, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0,        5'd0, 32'hF000F000};
    av[7]  = '{"srl",      4'd9,  2'd2, 2'd0, 32'h0,        32'h80000000, 32'h0,        5'd4, 32'h08000000};
    av[8]  = '{"sll_rs",   4'd8,  2'd0, 2'd0, 32'h24,       32'h1,        32'h0,        5'd0, 32'h10};
    av[9]  = '{"op11",     4'd11, 2'd0, 2'd0, 32'h5,        32'h7,        32'h0,        5'd0, 32'h0};
    av[10] = '{"srcb_zero",4'd0,  2'd0, 2'd2, 32'h5,        32'h7,        32'h9,        5'd0, 32'h5};
    av[11] = '{"srca_zero",4'd0,  2'd3, 2'd0, 32'h5,        32'h7,        32'h0,        5'd3, 32'h7};
    av[12] = '{"and_imm",  4'd2,  2'd0, 2'd1, 32'h0000F0F0, 32'h0,        32'h0000FF00, 5'd0, 32'h0000F000};

    bus.op = 6'h3F; bus.funct = 6'h00;
    clear_ex();

    // reset: me_* cleared
    @(posedge clk); @(posedge clk); #1;
    check("rst_me_alu_out", bus.me_alu_out, 32'h0);
    check("rst_me_ctrl", {29'd0, bus.me_mem2reg, bus.me_memwr, bus.me_regwr}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // decoder table
    for (int i = 0; i < 16; i++) begin
      bus.op = dv[i].op; bus.funct = dv[i].funct;
      #1;
      check({"dec_", dv[i].name}, {16'd0, ctrl_vec()}, {16'd0, dv[i].exp});
    end

    // ALU / operand select table
    for (int i = 0; i < 13; i++) begin
      bus.ex_alu_op  = av[i].alu;  bus.ex_alusrca = av[i].srca; bus.ex_alusrcb = av[i].srcb;
      bus.ex_rs_val  = av[i].rs;   bus.ex_rt_val  = av[i].rt;   bus.ex_imm     = av[i].imm;
      bus.ex_shamt   = av[i].shamt;
      #1;
      check({"alu_", av[i].name}, bus.ex_alu_out, av[i].exp);
    end

    // destination index select
    bus.ex_rt = 5'd7; bus.ex_rd = 5'd19;
    bus.ex_regdst = 1'b1; #1; check("wr_idx_rd", {27'd0, bus.ex_wr_idx}, 32'd19);
    bus.ex_regdst = 1'b0; #1; check("wr_idx_rt", {27'd0, bus.ex_wr_idx}, 32'd7);

    // store path: sw decode fed straight into EX
    @(negedge clk);
    bus.op = 6'h2B; bus.funct = 6'h00; #1;
    bus.ex_alu_op  = bus.ctrl_alu;     bus.ex_alusrca = bus.ctrl_alusrca;
    bus.ex_alusrcb = bus.ctrl_alusrcb; bus.ex_regdst  = bus.ctrl_regdst;
    bus.ex_mem2reg = bus.ctrl_mem2reg; bus.ex_memwr   = bus.ctrl_memwr;
    bus.ex_regwr   = bus.ctrl_regwr;
    bus.ex_rs_val = 32'h100; bus.ex_imm = 32'h8; bus.ex_rt_val = 32'hDEAD;
    @(posedge clk); #1;
    check("sw_me_alu_out", bus.me_alu_out, 32'h108);
    check("sw_me_wdata",   bus.me_wdata,   32'hDEAD);
    check("sw_me_memwr",   {31'd0, bus.me_memwr}, 32'd1);
    check("sw_me_regwr",   {31'd0, bus.me_regwr}, 32'd0);

    // load everything nonzero, then reset for one edge
    @(negedge clk);
    bus.ex_alu_op = 4'd0; bus.ex_alusrca = 2'd0; bus.ex_alusrcb = 2'd0;
    bus.ex_rs_val = 32'h11; bus.ex_rt_val = 32'h22; bus.ex_regdst = 1'b1; bus.ex_rd = 5'd5;
    bus.ex_mem2reg = 1'b1; bus.ex_memwr = 1'b1; bus.ex_regwr = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_me", {bus.me_alu_out[15:0], bus.me_wdata[7:0], bus.me_wr_idx,
                         bus.me_mem2reg, bus.me_memwr, bus.me_regwr}, {16'h0033, 8'h22, 5'd5, 3'b111});
    @(negedge clk); rst = 1'b1; bus.op = 6'h23;
    @(posedge clk); #1;
    check("rst2_me_alu_out", bus.me_alu_out, 32'h0);
    check("rst2_me_wdata",   bus.me_wdata,   32'h0);
    check("rst2_me_rest", {26'd0, bus.me_wr_idx, bus.me_mem2reg, bus.me_memwr, bus.me_regwr}, 32'h0);
    // combinational paths ignore rst
    check("rst_ctrl_lw", {16'd0, ctrl_vec()}, {16'd0, mk(4'd0, 0, 0, 1, 1, 1, 1, 0, 2'b00, 0)});
    check("rst_ex_alu_out", bus.ex_alu_out, 32'h33);
    @(negedge clk); rst = 1'b0; bus.op = 6'h3F; #1;
    check("nop_3f", {16'd0, ctrl_vec()}, 32'h0);

    // one cycle latency: a value change shows up exactly one edge later
    bus.ex_rs_val = 32'h1000; bus.ex_rt_val = 32'h1;
    @(posedge clk); #1;
    check("lat1", bus.me_alu_out, 32'h1001);
    @(negedge clk); bus.ex_rs_val = 32'h2000; #1;
    check("lat_hold", bus.me_alu_out, 32'h1001);

`ifdef EXME_FLUSH_EN
    @(negedge clk); flush = 1'b1; bus.ex_regwr = 1'b1; bus.ex_memwr = 1'b1; bus.ex_mem2reg = 1'b1;
    bus.ex_rs_val = 32'h40; bus.ex_rt_val = 32'h2;
    @(posedge clk); #1;
    check("flush_regwr", {29'd0, bus.me_mem2reg, bus.me_memwr, bus.me_regwr}, 32'h0);
    check("flush_alu_out", bus.me_alu_out, 32'h42);
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #1;
    check("unflush_regwr", {29'd0, bus.me_mem2reg, bus.me_memwr, bus.me_regwr}, 32'h7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
